mem_access_ctrl: RTL

Parametrised multi-cycle memory access controller for the 5-stage pipelined CPU. It sits between the pipeline (IF stage on the instruction side, MEM stage on the data side) and the two memory ports. It generalises fixed-delay memory sequencing to a configurable latency and adds fetch abort on flush, a protocol-error flag and saturating stall-cycle counters. The pipeline uses `i_stall`/`d_stall` as its freeze conditions and consumes data on `i_ready`/`d_ready`.

---
 rtl/mem_access_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access controller: independent instruction and data channels,
// each sequencing a fixed-latency memory access with ready/stall handshakes to the pipeline.
module mem_access_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic                 i_flush,
    output logic                 i_ready,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_stall,
    input  logic                 d_rd,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ready,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_stall,
    output logic                 read_m1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    output logic                 read_m2,
    output logic                 write_m2,
    output logic [WORD_SIZE-1:0] address2,
    output logic [WORD_SIZE-1:0] data2_out,
    input  logic [WORD_SIZE-1:0] data2_in,
    input  logic                 perf_clr,
    output logic [WORD_SIZE-1:0] i_stall_cnt,
    output logic [WORD_SIZE-1:0] d_stall_cnt,
    output logic                 proto_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [WORD_SIZE-1:0] CNT_MAX = {WORD_SIZE{1'b1}};

    function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v,
                                                     input logic en, input logic clr);
        if (clr)                   return {WORD_SIZE{1'b0}};
        else if (en && v != CNT_MAX) return v + {{(WORD_SIZE-1){1'b0}}, 1'b1};
        else                       return v;
    endfunction

    logic [1:0]           i_state_q, i_state_d, d_state_q, d_state_d;
    logic [3:0]           i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    logic                 i_discard_q, i_discard_d, d_wr_q, d_wr_d;
    logic [WORD_SIZE-1:0] i_addr_q, i_addr_d, i_data_q, i_data_d;
    logic [WORD_SIZE-1:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d, d_rdata_q, d_rdata_d;
    logic [WORD_SIZE-1:0] i_scnt_q, i_scnt_d, d_scnt_q, d_scnt_d;
    logic                 proto_q, proto_d;

    // Instruction channel next state; a flushed fetch still completes but never signals ready.
    always_comb begin
        i_state_d   = i_state_q;
        i_cnt_d     = i_cnt_q;
        i_discard_d = i_discard_q;
        i_addr_d    = i_addr_q;
        i_data_d    = i_data_q;
        case (i_state_q)
            ST_IDLE: begin
                i_discard_d = 1'b0;
                if (i_req && !i_flush) begin
                    i_state_d = ST_WAIT;
                    i_cnt_d   = CNT_LOAD;
                    i_addr_d  = i_addr;
                end else begin
                    i_state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_flush) i_discard_d = 1'b1;
                else         i_discard_d = i_discard_q;
                if (i_cnt_q != 4'd0) begin
                    i_cnt_d = i_cnt_q - 4'd1;
                end else begin
                    i_data_d  = data1;
                    i_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                i_state_d   = ST_IDLE;
                i_discard_d = 1'b0;
            end
            default: begin
                i_state_d   = ST_IDLE;
                i_discard_d = 1'b0;
            end
        endcase
    end

    // Data channel next state; a simultaneous read+write is served as a read only.
    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_wr_d    = d_wr_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_rdata_d = d_rdata_q;
        proto_d   = proto_q;
        case (d_state_q)
            ST_IDLE: begin
                if (d_rd || d_wr) begin
                    d_state_d = ST_WAIT;
                    d_cnt_d   = CNT_LOAD;
                    d_wr_d    = d_wr && !d_rd;
                    d_addr_d  = d_addr;
                    d_wdata_d = d_wdata;
                    proto_d   = proto_q | (d_rd & d_wr);
                end else begin
                    d_state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (d_cnt_q != 4'd0) begin
                    d_cnt_d = d_cnt_q - 4'd1;
                end else begin
                    if (!d_wr_q) d_rdata_d = data2_in;
                    else         d_rdata_d = d_rdata_q;
                    d_state_d = ST_DONE;
                end
            end
            ST_DONE: d_state_d = ST_IDLE;
            default: d_state_d = ST_IDLE;
        endcase
    end

    assign i_scnt_d = sat_inc(i_scnt_q, i_stall, perf_clr);
    assign d_scnt_d = sat_inc(d_scnt_q, d_stall, perf_clr);

    // State and datapath registers for both channels and the stall counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_state_q   <= ST_IDLE;
            i_cnt_q     <= 4'd0;
            i_discard_q <= 1'b0;
            i_addr_q    <= {WORD_SIZE{1'b0}};
            i_data_q    <= {WORD_SIZE{1'b0}};
            d_state_q   <= ST_IDLE;
            d_cnt_q     <= 4'd0;
            d_wr_q      <= 1'b0;
            d_addr_q    <= {WORD_SIZE{1'b0}};
            d_wdata_q   <= {WORD_SIZE{1'b0}};
            d_rdata_q   <= {WORD_SIZE{1'b0}};
            proto_q     <= 1'b0;
            i_scnt_q    <= {WORD_SIZE{1'b0}};
            d_scnt_q    <= {WORD_SIZE{1'b0}};
        end else begin
            i_state_q   <= i_state_d;
            i_cnt_q     <= i_cnt_d;
            i_discard_q <= i_discard_d;
            i_addr_q    <= i_addr_d;
            i_data_q    <= i_data_d;
            d_state_q   <= d_state_d;
            d_cnt_q     <= d_cnt_d;
            d_wr_q      <= d_wr_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            d_rdata_q   <= d_rdata_d;
            proto_q     <= proto_d;
            i_scnt_q    <= i_scnt_d;
            d_scnt_q    <= d_scnt_d;
        end
    end

    // i_flush in DONE suppresses the ready pulse in the same cycle.
    assign i_ready     = (i_state_q == ST_DONE) && !i_discard_q && !i_flush;
    assign d_ready     = (d_state_q == ST_DONE);
    assign i_stall     = i_req && !i_ready;
    assign d_stall     = (d_rd || d_wr) && !d_ready;
    assign read_m1     = (i_state_q == ST_WAIT);
    assign read_m2     = (d_state_q == ST_WAIT) && !d_wr_q;
    assign write_m2    = (d_state_q == ST_WAIT) && d_wr_q;
    assign address1    = i_addr_q;
    assign address2    = d_addr_q;
    assign data2_out   = d_wdata_q;
    assign i_data      = i_data_q;
    assign d_rdata     = d_rdata_q;
    assign i_stall_cnt = i_scnt_q;
    assign d_stall_cnt = d_scnt_q;
    assign proto_err   = proto_q;

endmodule
